// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer and lock supervisor.
// Runs on the PLL reference clock. It pulses the PLL reset, waits for a synchronized lock,
// qualifies lock stability before raising clk_ok, and retries failed attempts a bounded number
// of times before parking in a fault state that only software restart or reset can leave.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       clk_ok,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lol_count,
  output logic [2:0] state
);

  // State encodings are visible on the debug port and must stay fixed.
  localparam logic [2:0] StResetPll  = 3'd0;
  localparam logic [2:0] StWaitLock  = 3'd1;
  localparam logic [2:0] StStabilize = 3'd2;
  localparam logic [2:0] StRun       = 3'd3;
  localparam logic [2:0] StFault     = 3'd4;

  // One shared counter, wide enough for the longest of the three intervals.
  localparam int unsigned CntMaxA = (RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned CntMax  = (CntMaxA > LOCK_TIMEOUT_CYCLES) ?
                                    CntMaxA : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

  // Terminal counts: the counter runs 0..N-1, so the N-th cycle in a state sees N-1.
  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      MaxRetry    = 4'(MAX_RETRIES);
  localparam logic [7:0]      LolMax      = 8'hFF;

  logic [2:0]      sync_q;
  logic            lock_s;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic [7:0]      lol_q, lol_d;
  logic            pll_rst_q, pll_rst_d;
  logic            clk_ok_q, clk_ok_d;
  logic            fault_q, fault_d;

  logic            attempt_fail;
  logic            lol_event;

  // Capture stage followed by a two-flop synchronizer; lock_s is valid two edges after the
  // capture edge, so the state machine reacts on the third edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], pll_locked};
    end
  end

  assign lock_s = sync_q[2];

  // Next-state decision; restart overrides everything, a failed attempt is resolved afterwards.
  always_comb begin
    state_d      = state_q;
    attempt_fail = 1'b0;
    lol_event    = 1'b0;
    if (restart) begin
      state_d = StResetPll;
    end else begin
      case (state_q)
        StResetPll: begin
          if (cnt_q == RstLast) begin
            state_d = StWaitLock;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStabilize;
          end else if (cnt_q == TimeoutLast) begin
            attempt_fail = 1'b1;
          end
        end
        StStabilize: begin
          if (!lock_s) begin
            attempt_fail = 1'b1;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!lock_s) begin
            lol_event = 1'b1;
            state_d   = StResetPll;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StResetPll;
        end
      endcase
      if (attempt_fail) begin
        state_d = (retry_q == MaxRetry) ? StFault : StResetPll;
      end
    end
  end

  // Interval counter: cleared on every state change and while restart is held.
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (state_d != state_q) || attempt_fail) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        StResetPll, StWaitLock, StStabilize: cnt_d = cnt_q + CntW'(1);
        default:                             cnt_d = '0;
      endcase
    end
  end

  // Retry and loss-of-lock bookkeeping.
  always_comb begin
    retry_d = retry_q;
    lol_d   = lol_q;
    if (restart) begin
      retry_d = 4'd0;
    end else if (attempt_fail) begin
      if (retry_q != MaxRetry) begin
        retry_d = retry_q + 4'd1;
      end
    end else if ((state_q == StStabilize) && (state_d == StRun)) begin
      retry_d = 4'd0;
    end
    if (lol_event && (lol_q != LolMax)) begin
      lol_d = lol_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == StResetPll) || (state_d == StFault);
    clk_ok_d  = (state_d == StRun);
    fault_d   = (state_d == StFault);
  end

  // State, counters and registered outputs; pll_rst resets high so the PLL never sees a
  // release glitch when reset_n asserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StResetPll;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      lol_q     <= 8'd0;
      pll_rst_q <= 1'b1;
      clk_ok_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lol_q     <= lol_d;
      pll_rst_q <= pll_rst_d;
      clk_ok_q  <= clk_ok_d;
      fault_q   <= fault_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign clk_ok      = clk_ok_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign lol_count   = lol_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: vector table, directed corner sequences and
// randomized lock/restart stimulus against a phase-level reference model.
module tb_pll_reset_sequencer;

  localparam int RstC = 4;
  localparam int Stab = 8;
  localparam int Tmo  = 32;
  localparam int MaxR = 2;

  localparam int PhReset = 0;
  localparam int PhWait  = 1;
  localparam int PhStab  = 2;
  localparam int PhRun   = 3;
  localparam int PhFault = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       clk_ok;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lol_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_CYCLES         (RstC),
    .LOCK_STABLE_CYCLES (Stab),
    .LOCK_TIMEOUT_CYCLES(Tmo),
    .MAX_RETRIES        (MaxR)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .clk_ok     (clk_ok),
    .fault      (fault),
    .retry_count(retry_count),
    .lol_count  (lol_count),
    .state      (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves reset_n released at a falling edge, so the next rising edge is edge 1.
  task automatic apply_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_outs(input string name, input int st, input int prst, input int ok,
                            input int flt, input int rc);
    check({name, ".state"}, 32'(state), 32'(st));
    check({name, ".pll_rst"}, 32'(pll_rst), 32'(prst));
    check({name, ".clk_ok"}, 32'(clk_ok), 32'(ok));
    check({name, ".fault"}, 32'(fault), 32'(flt));
    check({name, ".retry"}, 32'(retry_count), 32'(rc));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int    rst;
    int    n;
    int    locked;
    int    rstrt;
    int    st;
    int    prst;
    int    ok;
    int    flt;
    int    rc;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rst, input int n, input int locked, input int rstrt,
                     input int st, input int prst, input int ok, input int flt, input int rc,
                     input string name);
    vec_t v;
    v.rst = rst; v.n = n; v.locked = locked; v.rstrt = rstrt;
    v.st = st; v.prst = prst; v.ok = ok; v.flt = flt; v.rc = rc; v.name = name;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Tracks the phase and how long it has lasted; lock decisions see pll_locked as sampled
  // three edges earlier.
  int m_ph, m_t, m_retry, m_lol;
  bit m_q[$];

  task automatic model_reset();
    m_ph = PhReset; m_t = 0; m_retry = 0; m_lol = 0;
    m_q.delete();
    for (int i = 0; i < 3; i++) m_q.push_back(1'b0);
  endtask

  task automatic model_fail();
    if (m_retry == MaxR) m_ph = PhFault;
    else begin
      m_retry++;
      m_ph = PhReset;
    end
    m_t = 0;
  endtask

  task automatic model_step(input bit lk_in, input bit rs);
    bit lk;
    lk = m_q.pop_front();
    m_q.push_back(lk_in);
    if (rs) begin
      m_ph = PhReset; m_t = 0; m_retry = 0;
    end else begin
      case (m_ph)
        PhReset: begin
          m_t++;
          if (m_t == RstC) begin m_ph = PhWait; m_t = 0; end
        end
        PhWait: begin
          if (lk) begin m_ph = PhStab; m_t = 0; end
          else begin
            m_t++;
            if (m_t == Tmo) model_fail();
          end
        end
        PhStab: begin
          if (!lk) model_fail();
          else begin
            m_t++;
            if (m_t == Stab) begin m_ph = PhRun; m_t = 0; m_retry = 0; end
          end
        end
        PhRun: begin
          if (!lk) begin
            if (m_lol < 255) m_lol++;
            m_ph = PhReset; m_t = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [17:0] model_outs();
    logic [2:0] code;
    case (m_ph)
      PhReset: code = 3'd0;
      PhWait:  code = 3'd1;
      PhStab:  code = 3'd2;
      PhRun:   code = 3'd3;
      default: code = 3'd4;
    endcase
    return {code, 1'((m_ph == PhReset) || (m_ph == PhFault)), 1'(m_ph == PhRun),
            1'(m_ph == PhFault), 4'(m_retry), 8'(m_lol)};
  endfunction

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seg;
    bit lvl;

    // Reset values, applied asynchronously before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check_outs("por", 0, 1, 0, 0, 0);
    check("por.lol", 32'(lol_count), 32'd0);

    // Nominal lock: lock first sampled at edge 14, STABILIZE at 17, RUN at 25.
    add(1, 3, 0, 0, 0, 1, 0, 0, 0, "nom_rst_hold");
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, "nom_rst_fall");
    add(0, 9, 0, 0, 1, 0, 0, 0, 0, "nom_wait");
    add(0, 3, 1, 0, 1, 0, 0, 0, 0, "nom_sync_lat");
    add(0, 1, 1, 0, 2, 0, 0, 0, 0, "nom_stab_in");
    add(0, 7, 1, 0, 2, 0, 0, 0, 0, "nom_stab_hold");
    add(0, 1, 1, 0, 3, 0, 1, 0, 0, "nom_run");
    // Timeout at edge 36, second attempt locks, RUN at 49.
    add(1, 4, 0, 0, 1, 0, 0, 0, 0, "to_wait_in");
    add(0, 31, 0, 0, 1, 0, 0, 0, 0, "to_wait_hold");
    add(0, 1, 0, 0, 0, 1, 0, 0, 1, "to_expire");
    add(0, 3, 1, 0, 0, 1, 0, 0, 1, "to_rst2_hold");
    add(0, 1, 1, 0, 1, 0, 0, 0, 1, "to_rst2_fall");
    add(0, 1, 1, 0, 2, 0, 0, 0, 1, "to_stab");
    add(0, 7, 1, 0, 2, 0, 0, 0, 1, "to_stab_hold");
    add(0, 1, 1, 0, 3, 0, 1, 0, 0, "to_run");
    // Three timeouts then FAULT at edge 108, parked, then restart.
    add(1, 36, 0, 0, 0, 1, 0, 0, 1, "flt_try2");
    add(0, 36, 0, 0, 0, 1, 0, 0, 2, "flt_try3");
    add(0, 35, 0, 0, 1, 0, 0, 0, 2, "flt_wait3");
    add(0, 1, 0, 0, 4, 1, 0, 1, 2, "flt_enter");
    add(0, 1000, 0, 0, 4, 1, 0, 1, 2, "flt_park");
    add(0, 1, 0, 1, 0, 1, 0, 0, 0, "flt_restart");
    add(0, 3, 0, 0, 0, 1, 0, 0, 0, "flt_rst_hold");
    add(0, 1, 0, 0, 1, 0, 0, 0, 0, "flt_rst_fall");

    foreach (vecs[i]) begin
      if (vecs[i].rst != 0) apply_reset();
      pll_locked = (vecs[i].locked != 0);
      restart    = (vecs[i].rstrt != 0);
      stepn(vecs[i].n);
      check_outs(vecs[i].name, vecs[i].st, vecs[i].prst, vecs[i].ok, vecs[i].flt, vecs[i].rc);
    end
    restart = 1'b0;

    // Glitch in STABILIZE: entered at edge 8, lock_s low seen at edge 14.
    apply_reset();
    stepn(4);
    check("gl.wait", 32'(state), 32'd1);
    pll_locked = 1'b1;
    stepn(4);
    check("gl.stab", 32'(state), 32'd2);
    stepn(2);
    pll_locked = 1'b0;
    stepn(3);
    pll_locked = 1'b1;
    check("gl.stab_still", 32'(state), 32'd2);
    check("gl.no_ok", 32'(clk_ok), 32'd0);
    step();
    check_outs("gl.fail", 0, 1, 0, 0, 1);
    stepn(3);
    check("gl.rst_hold", 32'(state), 32'd0);
    step();
    check("gl.wait2", 32'(state), 32'd1);
    step();
    check("gl.stab2", 32'(state), 32'd2);
    stepn(7);
    check("gl.stab2_ok", 32'(clk_ok), 32'd0);
    step();
    check_outs("gl.run", 3, 0, 1, 0, 0);

    // Loss of lock in RUN, repeated until lol_count saturates.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      stepn(3);
      if (i < 2) check("lol.pre_ok", 32'(clk_ok), 32'd1);
      step();
      if (i < 2) begin
        check("lol.ok_fall", 32'(clk_ok), 32'd0);
        check("lol.rst_rise", 32'(pll_rst), 32'd1);
      end
      check("lol.count", 32'(lol_count), 32'((i + 1 > 255) ? 255 : i + 1));
      pll_locked = 1'b1;
      stepn(4);
      if (i < 2) check("lol.wait", 32'(state), 32'd1);
      step();
      if (i < 2) check("lol.stab", 32'(state), 32'd2);
      stepn(8);
      check("lol.relock", 32'(state), 32'd3);
    end

    // Asynchronous reset in STABILIZE.
    pll_locked = 1'b0;
    stepn(4);
    pll_locked = 1'b1;
    stepn(5);
    check("ar.stab", 32'(state), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("ar", 0, 1, 0, 0, 0);
    check("ar.lol", 32'(lol_count), 32'd0);

    // Restart on the same edge as the last-allowed timeout, then held restart.
    apply_reset();
    stepn(107);
    check("rt.pre_state", 32'(state), 32'd1);
    check("rt.pre_retry", 32'(retry_count), 32'd2);
    restart = 1'b1;
    step();
    check_outs("rt.hit", 0, 1, 0, 0, 0);
    stepn(4);
    check("rt.held", 32'(state), 32'd0);
    restart = 1'b0;
    stepn(3);
    check("rt.rel_hold", 32'(state), 32'd0);
    step();
    check("rt.rel_wait", 32'(state), 32'd1);

    // Randomized lock/restart stimulus against the reference model.
    apply_reset();
    model_reset();
    seg = 0;
    lvl = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (seg == 0) begin
        lvl = ($urandom_range(0, 1) == 1);
        seg = lvl ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 150));
      end
      seg--;
      pll_locked = lvl;
      restart    = ($urandom_range(0, 249) == 0);
      step();
      model_step(pll_locked, restart);
      check("random", 32'({state, pll_rst, clk_ok, fault, retry_count, lol_count}),
            32'(model_outs()));
    end
    restart = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
